// File: rtl/bus_pkg.sv
// Shared definitions for the two-master valid/ready bus arbiter: FSM state
// encoding, timeout read-back data and default bus widths.
package bus_pkg;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

    // Read data returned to a master whose transaction was force-completed.
    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the valid/ready bus, one transaction per grant.
// Optional slave-hang timeout with sticky bus_err when BUS_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_dout,
    input  logic [DW/8-1:0] m0_lane,
    input  logic            m0_wr,
    input  logic            m0_valid,
    output logic [DW-1:0]   m0_din,
    output logic            m0_ready,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_dout,
    input  logic [DW/8-1:0] m1_lane,
    input  logic            m1_wr,
    input  logic            m1_valid,
    output logic [DW-1:0]   m1_din,
    output logic            m1_ready,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_dout,
    output logic [DW/8-1:0] s_lane,
    output logic            s_wr,
    output logic            s_valid,
    input  logic [DW-1:0]   s_din,
    input  logic            s_ready,
    output logic [1:0]      grant,
    output logic            bus_err
);

    state_t        state;
    logic [1:0]    grant_q;
    logic          rr_last;
    logic          own0;
    logic          own1;
    logic          owner_valid;
    logic          expire;
    logic          finish;
    logic          pick0;
    logic [DW-1:0] rd_data;

    assign own0        = grant_q[0];
    assign own1        = grant_q[1];
    assign owner_valid = (own0 & m0_valid) | (own1 & m1_valid);
    assign finish      = owner_valid & (s_ready | expire);

    // On a tie, m0 wins only if m1 was the last master served.
    assign pick0 = m0_valid & (~m1_valid | rr_last);

    assign rd_data = expire ? DW'(BUS_ERR_DATA) : s_din;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
            rr_last <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick0) begin
                        state   <= ST_OWN0;
                        grant_q <= 2'b01;
                    end else if (m1_valid) begin
                        state   <= ST_OWN1;
                        grant_q <= 2'b10;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    // A dropped valid is an abort: release the bus without touching fairness.
                    if (!owner_valid || finish) begin
                        state   <= ST_GAP;
                        grant_q <= 2'b00;
                        if (finish) rr_last <= own1;
                    end
                end
                ST_GAP: state <= ST_IDLE;
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE)
                cnt <= '0;
            else if (state == ST_OWN0 || state == ST_OWN1)
                cnt <= cnt + CW'(1);
            if (expire) err_q <= 1'b1;
        end
    end

    // A real s_ready in the expiry cycle takes precedence over the timeout.
    assign expire  = owner_valid & ~s_ready & (cnt == CW'(TIMEOUT));
    assign bus_err = err_q;
`else
    assign expire  = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign grant    = grant_q;
    assign s_valid  = owner_valid;
    assign s_addr   = own0 ? m0_addr : (own1 ? m1_addr : '0);
    assign s_dout   = own0 ? m0_dout : (own1 ? m1_dout : '0);
    assign s_lane   = own0 ? m0_lane : (own1 ? m1_lane : '0);
    assign s_wr     = own0 ? m0_wr   : (own1 ? m1_wr   : 1'b0);

    // Ready is gated by rst_n so a reset cycle never completes an in-flight access.
    assign m0_ready = own0 & finish & rst_n;
    assign m1_ready = own1 & finish & rst_n;
    assign m0_din   = own0 ? rd_data : '0;
    assign m1_din   = own1 ? rd_data : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; the timeout scenario runs only
// when BUS_TIMEOUT_EN is defined (bench sets TIMEOUT = 8).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr, m0_dout, m1_addr, m1_dout;
    logic [3:0]  m0_lane, m1_lane;
    logic        m0_wr, m0_valid, m1_wr, m1_valid;
    logic [31:0] m0_din, m1_din;
    logic        m0_ready, m1_ready;
    logic [31:0] s_addr, s_dout, s_din;
    logic [3:0]  s_lane;
    logic        s_wr, s_valid, s_ready;
    logic [1:0]  grant;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_lane(m0_lane), .m0_wr(m0_wr),
        .m0_valid(m0_valid), .m0_din(m0_din), .m0_ready(m0_ready),
        .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_lane(m1_lane), .m1_wr(m1_wr),
        .m1_valid(m1_valid), .m1_din(m1_din), .m1_ready(m1_ready),
        .s_addr(s_addr), .s_dout(s_dout), .s_lane(s_lane), .s_wr(s_wr),
        .s_valid(s_valid), .s_din(s_din), .s_ready(s_ready),
        .grant(grant), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog expired");
    end

    // Advance to the next negedge (+1) and count grant==00 cycles until a grant appears.
    task automatic wait_grant(output int idle);
        idle = 0;
        while (grant == 2'b00 && idle < 8) begin
            idle++;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_ready = 1'b0; s_din = '0;
        m0_addr = 32'h0000_0100; m0_dout = 32'h1111_1111; m0_lane = 4'hF; m0_wr = 1'b0; m0_valid = 1'b1;
        m1_addr = 32'h0000_0200; m1_dout = 32'h2222_2222; m1_lane = 4'hF; m1_wr = 1'b0; m1_valid = 1'b1;
        repeat (2) @(negedge clk); #1;
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", grant); end
        n_cmp++; if (s_valid !== 1'b0 || s_addr !== 32'h0) begin n_bad++; $display("FAIL reset_slave: got valid=%b addr=%h expected 0/0", s_valid, s_addr); end
        n_cmp++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got r0=%b r1=%b err=%b expected 0", m0_ready, m1_ready, bus_err); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL first_grant: got %b expected 01", grant); end
        n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL first_slave: got valid=%b addr=%h expected 1/00000100", s_valid, s_addr); end
        s_din = 32'h1234_5678; s_ready = 1'b1; #1;
        n_cmp++; if (m0_ready !== 1'b1 || m0_din !== 32'h1234_5678) begin n_bad++; $display("FAIL first_read: got ready=%b din=%h expected 1/12345678", m0_ready, m0_din); end
        n_cmp++; if (m1_ready !== 1'b0 || m1_din !== 32'h0) begin n_bad++; $display("FAIL first_other: got m1_ready=%b m1_din=%h expected 0/0", m1_ready, m1_din); end
        @(negedge clk); s_ready = 1'b0; #1;
        n_cmp++; if (grant !== 2'b00 || s_valid !== 1'b0 || m0_ready !== 1'b0) begin n_bad++; $display("FAIL first_gap: got grant=%b valid=%b ready=%b expected 00/0/0", grant, s_valid, m0_ready); end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g [4];
        int idle;
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wait_grant(idle);
            n_cmp++; if (grant !== exp_g[i]) begin n_bad++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, grant, exp_g[i]); end
            n_cmp++; if (idle !== 2) begin n_bad++; $display("FAIL alt_gap[%0d]: got %0d idle cycles expected 2", i, idle); end
            repeat (2) @(negedge clk); #1;
            n_cmp++; if (s_valid !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_bad++; $display("FAIL alt_wait[%0d]: got valid=%b r0=%b r1=%b expected 1/0/0", i, s_valid, m0_ready, m1_ready); end
            s_din = 32'hA0 + 32'(i); s_ready = 1'b1; #1;
            if (exp_g[i] == 2'b01) begin
                n_cmp++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_din !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL alt_done[%0d]: got r0=%b r1=%b din=%h", i, m0_ready, m1_ready, m0_din); end
            end else begin
                n_cmp++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_din !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL alt_done[%0d]: got r0=%b r1=%b din=%h", i, m0_ready, m1_ready, m1_din); end
            end
            @(negedge clk); s_ready = 1'b0; #1;
        end
    endtask

    task automatic test_m1_write;
        int idle;
        m0_valid = 1'b0;
        m1_addr = 32'h8000_0010; m1_lane = 4'b0011; m1_dout = 32'hAABB_CCDD; m1_wr = 1'b1; m1_valid = 1'b1;
        wait_grant(idle);
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL wr_grant: got %b expected 10", grant); end
        n_cmp++; if (s_addr !== 32'h8000_0010 || s_lane !== 4'b0011 || s_dout !== 32'hAABB_CCDD || s_wr !== 1'b1 || s_valid !== 1'b1)
            begin n_bad++; $display("FAIL wr_slave: got addr=%h lane=%b dout=%h wr=%b valid=%b", s_addr, s_lane, s_dout, s_wr, s_valid); end
        s_ready = 1'b1; #1;
        n_cmp++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready: got r1=%b r0=%b expected 1/0", m1_ready, m0_ready); end
        @(negedge clk); s_ready = 1'b0; m1_valid = 1'b0; m1_wr = 1'b0; #1;
    endtask

    task automatic test_idle_ready;
        int bad = 0;
        s_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            if (grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || s_valid !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_ready: got %0d bad cycles expected 0", bad); end
        s_ready = 1'b0;
    endtask

    task automatic test_abort;
        int idle;
        m0_addr = 32'h0000_0300; m0_valid = 1'b1; m1_valid = 1'b1;
        wait_grant(idle);
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL abort_grant: got %b expected 01", grant); end
        m0_valid = 1'b0; s_ready = 1'b1; #1;
        n_cmp++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_bad++; $display("FAIL abort_noready: got valid=%b r0=%b r1=%b expected 0/0/0", s_valid, m0_ready, m1_ready); end
        @(negedge clk); s_ready = 1'b0; m0_valid = 1'b1; #1;
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL abort_gap: got %b expected 00", grant); end
        wait_grant(idle);
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL abort_regrant: got %b expected 01", grant); end
        s_din = 32'h0BAD_F00D; s_ready = 1'b1; #1;
        n_cmp++; if (m0_ready !== 1'b1 || m0_din !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL abort_retry: got ready=%b din=%h expected 1/0badf00d", m0_ready, m0_din); end
        @(negedge clk); s_ready = 1'b0; #1;
    endtask

    task automatic test_reset_mid;
        int idle;
        wait_grant(idle);
        n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL rmid_grant: got %b expected 10", grant); end
        rst_n = 1'b0; s_ready = 1'b1; #1;
        n_cmp++; if (m1_ready !== 1'b0 || m0_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_noready: got r1=%b r0=%b expected 0/0", m1_ready, m0_ready); end
        @(negedge clk); #1;
        n_cmp++; if (grant !== 2'b00 || s_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_cleared: got grant=%b valid=%b expected 00/0", grant, s_valid); end
        rst_n = 1'b1; s_ready = 1'b0;
        wait_grant(idle);
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rmid_tie: got %b expected 01", grant); end
        s_ready = 1'b1; #1;
        @(negedge clk); s_ready = 1'b0; m1_valid = 1'b0; #1;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout;
        int idle;
        int early = 0;
        m0_valid = 1'b1;
        wait_grant(idle);
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL to_grant: got %b expected 01", grant); end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk); #1;
            if (m0_ready !== 1'b0) early++;
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL to_early: got %0d early pulses expected 0", early); end
        @(negedge clk); #1;
        n_cmp++; if (m0_ready !== 1'b1 || m0_din !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_expire: got ready=%b din=%h expected 1/ffffffff", m0_ready, m0_din); end
        @(negedge clk); m0_valid = 1'b0; #1;
        n_cmp++; if (bus_err !== 1'b1 || grant !== 2'b00) begin n_bad++; $display("FAIL to_err: got err=%b grant=%b expected 1/00", bus_err, grant); end
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b expected 1", bus_err); end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; m0_valid = 1'b1; #1;
        wait_grant(idle);
        repeat (8) @(negedge clk);
        #1; s_din = 32'h5555_AAAA; s_ready = 1'b1; #1;
        n_cmp++; if (m0_ready !== 1'b1 || m0_din !== 32'h5555_AAAA) begin n_bad++; $display("FAIL to_race: got ready=%b din=%h expected 1/5555aaaa", m0_ready, m0_din); end
        @(negedge clk); s_ready = 1'b0; m0_valid = 1'b0; #1;
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL to_race_err: got %b expected 0", bus_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_m1_write();
        test_idle_ready();
        test_abort();
        test_reset_mid();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
